// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the datapath clients and adder_arbiter.
// master = client side, slave = arbiter side.
// Optional overflow flag rsp_ovf is present only when ADDER_ARB_OVF_EN is defined.
interface adder_arbiter_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_cin;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_co;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;
`ifdef ADDER_ARB_OVF_EN
    logic                     rsp_ovf;
`endif

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id, busy
`ifdef ADDER_ARB_OVF_EN
        , input rsp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id, busy
`ifdef ADDER_ARB_OVF_EN
        , output rsp_ovf
`endif
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one ripple-carry adder among
// NUM_REQ requesters. IDLE -> COMPUTE -> RESP, one operation per 3 cycles.
// Optional macro ADDER_ARB_OVF_EN adds a registered two's-complement overflow flag.

// Combinational ripple-carry adder, one full-adder cell per bit.
module adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    logic [WIDTH:0] c;

    assign c[0] = cin;
    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign sum[g]  = a[g] ^ b[g] ^ c[g];
        assign c[g+1]  = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
    end
    assign co = c[WIDTH];
endmodule

module adder_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4
) (
    input logic             clk,
    input logic             rst_n,
    adder_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [WIDTH-1:0]  op_a, op_b;
    logic              op_cin;
    logic [ID_W-1:0]   op_id;

    logic [WIDTH-1:0]  rsp_sum_q;
    logic              rsp_co_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_valid_q;
    logic              busy_q;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [WIDTH-1:0]  add_sum;
    logic              add_co;
    logic [ID_W-1:0]   next_ptr;

    // The adder only ever sees the latched operands, never the live request bus.
    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .sum (add_sum),
        .co  (add_co)
    );

    // Round-robin pick: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_vld && bus.req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    // The served requester drops to lowest priority next round.
    assign next_ptr = (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + ID_W'(1);

    assign bus.req_ready = (state == IDLE && win_vld) ? (NUM_REQ'(1) << win_id) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_co    = rsp_co_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;

`ifdef ADDER_ARB_OVF_EN
    logic rsp_ovf_q;
    assign bus.rsp_ovf = rsp_ovf_q;

    // Overflow: operands agree in sign but the sum does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_ovf_q <= 1'b0;
        else if (state == COMPUTE)
            rsp_ovf_q <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
    end
`endif

    // Arbitration FSM: grant and latch, register the sum, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            op_id       <= '0;
            rsp_sum_q   <= '0;
            rsp_co_q    <= 1'b0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        op_a   <= bus.req_a[win_id*WIDTH +: WIDTH];
                        op_b   <= bus.req_b[win_id*WIDTH +: WIDTH];
                        op_cin <= bus.req_cin[win_id];
                        op_id  <= win_id;
                        state  <= COMPUTE;
                        busy_q <= 1'b1;
                    end
                end
                COMPUTE: begin
                    rsp_sum_q   <= add_sum;
                    rsp_co_q    <= add_co;
                    rsp_id_q    <= op_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a scoreboard: expected results are
// queued at each observed grant and checked when the response is accepted.
module tb_adder_arbiter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
    adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0]  sum;
        logic          co;
        logic [IW-1:0] id;
        logic          ovf;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   n_chk = 0, n_pass = 0, cyc = 0, n_rsp = 0, exp_ptr = 0;
    logic [N-1:0]  last_ready;
    logic          prev_v = 1'b0, prev_r = 1'b0;
    logic [W-1:0]  prev_sum, last_sum;
    logic          prev_co, last_co;
    logic [IW-1:0] prev_id, last_id;
    logic          last_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic observe();
        exp_t e;
        int w;
        logic [W:0] full;
        logic [W-1:0] a, b;
        logic ci;
        last_ready = bus.req_ready;
        if (bus.req_ready != '0) begin
            w = rr_pick(bus.req_valid, exp_ptr);
            chk("grant", 64'(bus.req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
            if (w >= 0) begin
                a     = bus.req_a[w*W +: W];
                b     = bus.req_b[w*W +: W];
                ci    = bus.req_cin[w];
                full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                e.sum = full[W-1:0];
                e.co  = full[W];
                e.id  = IW'(w);
                e.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
                e.cyc = cyc;
                q.push_back(e);
                grant_log.push_back(w);
                grant_cyc.push_back(cyc);
            end
        end
        if (bus.rsp_valid) begin
            chk("ready_in_resp", 64'(bus.req_ready), 64'd0);
            if (!prev_v) begin
                if (q.size() == 0) chk("spurious_rsp", 64'd1, 64'd0);
                else               chk("latency", 64'(cyc), 64'(q[0].cyc + 2));
            end
        end
        if (prev_v && !prev_r) begin
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_sum",   64'(bus.rsp_sum),   64'(prev_sum));
            chk("hold_co",    64'(bus.rsp_co),    64'(prev_co));
            chk("hold_id",    64'(bus.rsp_id),    64'(prev_id));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) chk("rsp_no_expect", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("rsp_sum", 64'(bus.rsp_sum), 64'(e.sum));
                chk("rsp_co",  64'(bus.rsp_co),  64'(e.co));
                chk("rsp_id",  64'(bus.rsp_id),  64'(e.id));
`ifdef ADDER_ARB_OVF_EN
                chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(e.ovf));
                last_ovf = bus.rsp_ovf;
`endif
                exp_ptr = (int'(e.id) + 1) % N;
            end
            last_sum = bus.rsp_sum;
            last_co  = bus.rsp_co;
            last_id  = bus.rsp_id;
            n_rsp++;
        end
        prev_v   = bus.rsp_valid;
        prev_r   = bus.rsp_ready;
        prev_sum = bus.rsp_sum;
        prev_co  = bus.rsp_co;
        prev_id  = bus.rsp_id;
    endtask

    task automatic tick();
        #1;
        if (rst_n) observe();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_cin[i]      = ci;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic wait_grant(input int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            tick();
            ok = last_ready[i];
        end
        if (!ok) chk($sformatf("grant%0d_timeout", i), 64'd0, 64'd1);
    endtask

    task automatic wait_rsp();
        int t;
        t = n_rsp + 1;
        for (int k = 0; k < 20 && n_rsp < t; k++) tick();
        if (n_rsp < t) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) tick();
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic clear_model();
        q.delete();
        grant_log.delete();
        grant_cyc.delete();
        exp_ptr    = 0;
        prev_v     = 1'b0;
        prev_r     = 1'b0;
        last_ready = '0;
    endtask

    initial begin
        int n;
        bit seen;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b1;
        last_ready    = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
        chk("rst_rsp_co",    64'(bus.rsp_co),    64'd0);
        chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
`ifdef ADDER_ARB_OVF_EN
        chk("rst_rsp_ovf",   64'(bus.rsp_ovf),   64'd0);
`endif
        rst_n = 1'b1;

        // single request from requester 2
        set_req(2, 16'h1234, 16'h0FF0, 1'b0);
        wait_grant(2);
        bus.req_valid[2] = 1'b0;
        #1 chk("busy_compute", 64'(bus.busy), 64'd1);
        wait_rsp();
        #1;
        chk("tp1_sum",  64'(last_sum), 64'h2224);
        chk("tp1_co",   64'(last_co),  64'd0);
        chk("tp1_id",   64'(last_id),  64'd2);
        chk("tp1_busy", 64'(bus.busy), 64'd0);

        // carry wrap
        set_req(0, 16'hFFFF, 16'h0000, 1'b1);
        wait_grant(0);
        bus.req_valid[0] = 1'b0;
        wait_rsp();
        chk("wrap_sum", 64'(last_sum), 64'h0000);
        chk("wrap_co",  64'(last_co),  64'd1);
`ifdef ADDER_ARB_OVF_EN
        set_req(0, 16'h7FFF, 16'h0001, 1'b0);
        wait_grant(0);
        bus.req_valid[0] = 1'b0;
        wait_rsp();
        chk("ovf_sum", 64'(last_sum), 64'h8000);
        chk("ovf_flag", 64'(last_ovf), 64'd1);
`endif

        // round-robin with all requesters valid from reset
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < N; i++)
            set_req(i, 16'(16'h1000 * (i + 1) + 16'h0011), 16'(16'h0101 * (i + 3)), 1'(i & 1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40 && grant_log.size() < 6; k++) tick();
        bus.req_valid = '0;
        chk("rr_count", 64'(grant_log.size()), 64'd6);
        if (grant_log.size() >= 6) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("rr_order%0d", k), 64'(grant_log[k]), 64'(k % N));
            for (int k = 1; k < 6; k++)
                chk($sformatf("rr_gap%0d", k), 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd3);
        end
        wait_drain();

        // backpressure: response held for 5 extra cycles, requester 3 waits
        bus.rsp_ready = 1'b0;
        set_req(1, 16'hA5A5, 16'h1111, 1'b1);
        wait_grant(1);
        bus.req_valid[1] = 1'b0;
        set_req(3, 16'h0F0F, 16'h0101, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = bus.rsp_valid;
        end
        chk("bp_rsp_seen", 64'(seen), 64'd1);
        n = grant_log.size();
        repeat (5) tick();
        chk("bp_no_grant", 64'(grant_log.size()), 64'(n));
        chk("bp_busy",     64'(bus.busy),         64'd1);
        bus.rsp_ready = 1'b1;
        wait_grant(3);
        bus.req_valid[3] = 1'b0;
        wait_drain();

        // fairness: after 1 is served, 3 beats 1
        set_req(1, 16'h0001, 16'h0002, 1'b0);
        wait_grant(1);
        bus.req_valid[1] = 1'b0;
        wait_drain();
        grant_log.delete();
        grant_cyc.delete();
        set_req(1, 16'h0003, 16'h0004, 1'b0);
        set_req(3, 16'h0005, 16'h0006, 1'b1);
        wait_grant(3);
        bus.req_valid[3] = 1'b0;
        wait_grant(1);
        bus.req_valid[1] = 1'b0;
        wait_drain();
        if (grant_log.size() > 0) chk("fair_first", 64'(grant_log[0]), 64'd3);
        else                      chk("fair_first_missing", 64'd0, 64'd1);

        // async reset while COMPUTE; rr pointer must restart at 0
        set_req(1, 16'h4444, 16'h5555, 1'b0);
        wait_grant(1);
        bus.req_valid[1] = 1'b0;
        #1 chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("arst_busy",      64'(bus.busy),      64'd0);
        clear_model();
        set_req(2, 16'h2222, 16'h0002, 1'b0);
        set_req(0, 16'h3333, 16'h0003, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(0);
        bus.req_valid[0] = 1'b0;
        wait_grant(2);
        bus.req_valid[2] = 1'b0;
        wait_drain();
        if (grant_log.size() > 0) chk("rst_first_grant", 64'(grant_log[0]), 64'd0);
        else                      chk("rst_first_missing", 64'd0, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one combinational ripple-carry `adder` instance (WIDTH bits, carry-in, carry-out) between NUM_REQ requesters.
- Grants by round-robin, latches the winner's operands, registers the sum, and returns it on a single response channel tagged with the requester ID.
- Sits between the datapath clients and the shared arithmetic resource, so each client never drives the adder directly.

Parameters:
- WIDTH, 16, operand/sum width passed to the shared `adder` instance.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  flattened operand A; requester i occupies [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened operand B, same packing as req_a.
- req_cin  input  NUM_REQ  per-requester carry-in.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_sum  output  WIDTH  registered sum.
- rsp_co  output  1  registered carry-out.
- rsp_id  output  ID_W  index of the requester that owns the response.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, rr_ptr=0, op_a/op_b/op_cin/op_id=0. Outputs: rsp_valid=0, rsp_sum=0, rsp_co=0, rsp_id=0, req_ready=0, busy=0.
- FSM states: IDLE, COMPUTE, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1, combinationally, in the same cycle; all other req_ready bits are 0.
  - At the clock edge, latch op_a, op_b, op_cin and op_id=winner, then go to COMPUTE.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- COMPUTE:
  - The adder is driven only from op_a/op_b/op_cin, never from the req_* inputs.
  - At the clock edge, rsp_sum and rsp_co capture the adder outputs, rsp_id takes op_id, rsp_valid goes to 1, and the state goes to RESP.
  - req_ready=0.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0 (backpressure of any length).
  - On the cycle where rsp_valid && rsp_ready: rsp_valid goes to 0, rr_ptr takes (op_id+1) mod NUM_REQ, and the state goes to IDLE.
  - req_ready=0.
- Latency and throughput:
  - Request handshake in cycle T gives rsp_valid=1 in cycle T+2 (counted from the edge at the end of T).
  - Maximum throughput is one operation per 3 cycles.
- Arithmetic: {rsp_co, rsp_sum} = op_a + op_b + op_cin, modulo 2^(WIDTH+1). The wrap to 0 with co=1 is correct behaviour.
- Fairness: after requester k is served, k has the lowest priority in the next arbitration. A continuously requesting requester waits at most NUM_REQ-1 grants.
- Requester rules:
  - Must hold req_valid, req_a, req_b and req_cin stable until req_ready.
  - Dropping req_valid before it is granted is allowed; no grant is then made to that requester.
- Reset mid-operation: any in-flight operation is discarded and rsp_valid drops immediately (asynchronously). After release, the first arbitration starts from requester 0.
- busy=1 in COMPUTE and in RESP.

Optional Feature:
- Macro: ADDER_ARB_OVF_EN.
- When defined:
  - Extra output rsp_ovf (1 bit) gives registered two's-complement overflow.
  - rsp_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]).
  - It is captured in COMPUTE, held in RESP, and reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single request, no backpressure: requester 2 sends a=16'h1234, b=16'h0FF0, cin=0, with rsp_ready=1. Expect req_ready[2]=1 in the request cycle; rsp_valid two edges later with sum=16'h2224, co=0, id=2; busy=0 afterwards.
- Carry wrap: requester 0 sends a=16'hFFFF, b=16'h0000, cin=1. Expect sum=16'h0000, co=1. With ADDER_ARB_OVF_EN, a=16'h7FFF, b=16'h0001, cin=0 gives sum=16'h8000 and ovf=1.
- Round-robin: all 4 requesters hold valid continuously from reset. Expect grant order 0,1,2,3,0,1 and rsp_id in the same order, each response 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles during RESP. Expect rsp_sum/co/id held constant, req_ready=0 throughout, and no second grant until the response handshake.
- Fairness after a win: requester 1 is served, then requesters 1 and 3 are both valid. Expect requester 3 to be granted next.
- Async reset mid-op: assert rst_n=0 during COMPUTE. Expect rsp_valid=0 and busy=0 immediately; after release with requesters 2 and 0 valid, expect requester 0 to be granted first.
